// File: rtl/pea_cmd_fetch_param.sv
// rtl/pea_cmd_fetch_param.sv - PEA command fetch: decode, limit check, atomic operand fetch and stream
module pea_cmd_fetch_param #(
    parameter int WIDTH    = 16,
    parameter int POP_W    = 10,
    parameter int NUM_SETS = 4,
    parameter int SET_W    = 2,
    parameter int MAX_DEG  = 10,
    parameter int MAX_B    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               invoke,
    input  logic [WIDTH-1:0]   cmd_in,
    input  logic [POP_W-1:0]   cmd_pop,
    output logic               rd_cmd,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [POP_W-1:0]   data_pop,
    output logic               rd_data,
    output logic [7:0]         instr,
    output logic [SET_W-1:0]   arg1,
    output logic [4:0]         arg2,
    output logic [1:0]         cmd_err,
    output logic [WIDTH-1:0]   word_out,
    output logic [4:0]         word_idx,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               busy,
    output logic               FC
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_POP_CMD,
        S_LATCH_CMD,
        S_CHECK,
        S_WAIT_DATA,
        S_POP_DATA,
        S_LATCH_DATA,
        S_OFFER,
        S_DONE
    } state_t;

    localparam logic [4:0] MAX_DEG_L  = 5'(MAX_DEG);
    localparam logic [4:0] MAX_B_L    = 5'(MAX_B);
    localparam logic [3:0] NUM_SETS_L = 4'(NUM_SETS);

    state_t             state_q, state_d;
    logic [7:0]         instr_q, instr_d;
    logic [SET_W-1:0]   arg1_q, arg1_d;
    logic [4:0]         arg2_q, arg2_d;
    logic [1:0]         cmd_err_q, cmd_err_d;
    logic [WIDTH-1:0]   word_out_q, word_out_d;
    logic [4:0]         word_idx_q, word_idx_d;

    logic [5:0]         cnt;
    logic [1:0]         chk_err;
    logic               unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_in;

    // Operand count is derived from the held fields, so it stays valid for the whole firing.
    always_comb begin
        cnt = 6'd0;
        case (instr_q)
            8'd0:    cnt = {1'b0, arg2_q} + 6'd1;
            8'd1:    cnt = 6'd1;
            8'd2:    cnt = {1'b0, arg2_q};
            default: cnt = 6'd0;
        endcase
    end

    always_comb begin
        chk_err = 2'd0;
        if (instr_q > 8'd3) begin
            chk_err = 2'd1;
        end else if ({{(4-SET_W){1'b0}}, arg1_q} >= NUM_SETS_L) begin
            chk_err = 2'd2;
        end else if (instr_q == 8'd0 && arg2_q > MAX_DEG_L) begin
            chk_err = 2'd2;
        end else if (instr_q == 8'd2 && (arg2_q == 5'd0 || arg2_q > MAX_B_L)) begin
            chk_err = 2'd2;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        arg1_d     = arg1_q;
        arg2_d     = arg2_q;
        cmd_err_d  = cmd_err_q;
        word_out_d = word_out_q;
        word_idx_d = word_idx_q;
        case (state_q)
            S_IDLE: begin
                if (invoke) begin
                    if (cmd_pop != '0) begin
                        state_d = S_POP_CMD;
                    end else begin
                        // Empty FIFO passes through CHECK so FC lands two cycles after invoke.
                        cmd_err_d = 2'd3;
                        state_d   = S_CHECK;
                    end
                end
            end
            S_POP_CMD: state_d = S_LATCH_CMD;
            S_LATCH_CMD: begin
                instr_d   = cmd_in[7:0];
                arg1_d    = cmd_in[8+SET_W-1:8];
                arg2_d    = cmd_in[15:11];
                cmd_err_d = 2'd0;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (cmd_err_q == 2'd3) begin
                    state_d = S_DONE;
                end else if (chk_err != 2'd0) begin
                    cmd_err_d = chk_err;
                    state_d   = S_DONE;
                end else if (cnt == 6'd0) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = 5'd0;
                    state_d    = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (32'(data_pop) >= 32'(cnt)) begin
                    state_d = S_POP_DATA;
                end
            end
            S_POP_DATA: state_d = S_LATCH_DATA;
            S_LATCH_DATA: begin
                word_out_d = data_in;
                state_d    = S_OFFER;
            end
            S_OFFER: begin
                if (word_ready) begin
                    if ({1'b0, word_idx_q} == cnt - 6'd1) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d = word_idx_q + 5'd1;
                        state_d    = S_POP_DATA;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            instr_q    <= 8'd0;
            arg1_q     <= '0;
            arg2_q     <= 5'd0;
            cmd_err_q  <= 2'd0;
            word_out_q <= '0;
            word_idx_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            arg1_q     <= arg1_d;
            arg2_q     <= arg2_d;
            cmd_err_q  <= cmd_err_d;
            word_out_q <= word_out_d;
            word_idx_q <= word_idx_d;
        end
    end

    assign rd_cmd     = (state_q == S_POP_CMD);
    assign rd_data    = (state_q == S_POP_DATA);
    assign word_valid = (state_q == S_OFFER);
    assign busy       = (state_q != S_IDLE);
    assign FC         = (state_q == S_DONE);
    assign instr      = instr_q;
    assign arg1       = arg1_q;
    assign arg2       = arg2_q;
    assign cmd_err    = cmd_err_q;
    assign word_out   = word_out_q;
    assign word_idx   = word_idx_q;

endmodule

// File: tb/tb_pea_cmd_fetch_param.sv
// tb/tb_pea_cmd_fetch_param.sv - self-checking bench for pea_cmd_fetch_param
module tb_pea_cmd_fetch_param;

    localparam int WIDTH = 16;
    localparam int POP_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              invoke;
    logic [WIDTH-1:0]  cmd_in = '0;
    logic [POP_W-1:0]  cmd_pop = '0;
    logic              rd_cmd;
    logic [WIDTH-1:0]  data_in = '0;
    logic [POP_W-1:0]  data_pop = '0;
    logic              rd_data;
    logic [7:0]        instr;
    logic [1:0]        arg1;
    logic [4:0]        arg2;
    logic [1:0]        cmd_err;
    logic [WIDTH-1:0]  word_out;
    logic [4:0]        word_idx;
    logic              word_valid;
    logic              word_ready = 1'b0;
    logic              busy;
    logic              FC;

    pea_cmd_fetch_param dut (
        .clk(clk), .rst(rst), .invoke(invoke),
        .cmd_in(cmd_in), .cmd_pop(cmd_pop), .rd_cmd(rd_cmd),
        .data_in(data_in), .data_pop(data_pop), .rd_data(rd_data),
        .instr(instr), .arg1(arg1), .arg2(arg2), .cmd_err(cmd_err),
        .word_out(word_out), .word_idx(word_idx), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .FC(FC)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] cmd_q_m[$];
    logic [15:0] data_q_m[$];
    logic [15:0] exp_data[$];
    int          ready_pct = 100;

    // FIFO models: read data appears the cycle after the read pulse.
    initial forever begin
        logic pc, pd;
        @(posedge clk);
        pc = rd_cmd;
        pd = rd_data;
        #1;
        if (pc && cmd_q_m.size() > 0) cmd_in = cmd_q_m.pop_front();
        if (pd && data_q_m.size() > 0) data_in = data_q_m.pop_front();
        cmd_pop  = POP_W'(cmd_q_m.size());
        data_pop = POP_W'(data_q_m.size());
    end

    initial forever begin
        @(posedge clk);
        #1;
        word_ready = ($urandom_range(99) < ready_pct);
    end

    logic [15:0] hs_word[$];
    logic [4:0]  hs_idx[$];
    int rdd_cnt = 0, rdc_cnt = 0, fc_cnt = 0, fc_cyc = 0, last_hs_cyc = 0, overlap = 0;

    always @(negedge clk) begin
        if (word_valid && word_ready) begin
            hs_word.push_back(word_out);
            hs_idx.push_back(word_idx);
            last_hs_cyc = cyc;
        end
        if (rd_data) rdd_cnt = rdd_cnt + 1;
        if (rd_cmd) rdc_cnt = rdc_cnt + 1;
        if (rd_cmd && rd_data) overlap = overlap + 1;
        if (FC) begin
            fc_cnt = fc_cnt + 1;
            fc_cyc = cyc;
        end
    end

    int n_pass = 0, n_total = 0;
    int t0, base_hs, base_rdd, base_rdc, base_fc, base_ov;
    logic [7:0] prev_instr;
    logic [1:0] prev_arg1;
    logic [4:0] prev_arg2;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic push_data(input logic [15:0] v);
        data_q_m.push_back(v);
        exp_data.push_back(v);
    endtask

    function automatic void model(input logic [15:0] c, output logic [1:0] e, output int n);
        int op, a1, a2;
        op = int'(c[7:0]);
        a1 = int'(c[9:8]);
        a2 = int'(c[15:11]);
        e = 2'd0;
        n = 0;
        if (op > 3) e = 2'd1;
        else if (a1 >= 4) e = 2'd2;
        else if (op == 0 && a2 > 10) e = 2'd2;
        else if (op == 2 && (a2 == 0 || a2 > 16)) e = 2'd2;
        if (e == 2'd0) begin
            case (op)
                0: n = a2 + 1;
                1: n = 1;
                2: n = a2;
                default: n = 0;
            endcase
        end
    endfunction

    task automatic start_firing(input logic [15:0] c, input bit have_cmd, input int ndata, input int rp);
        if (have_cmd) cmd_q_m.push_back(c);
        for (int i = 0; i < ndata; i++) push_data(16'($urandom));
        ready_pct = rp;
        repeat (2) @(posedge clk);
        #1;
        base_hs  = hs_word.size();
        base_rdd = rdd_cnt;
        base_rdc = rdc_cnt;
        base_fc  = fc_cnt;
        base_ov  = overlap;
        invoke   = 1'b1;
        t0       = cyc;
        @(posedge clk);
        #1;
        invoke = 1'b0;
    endtask

    task automatic finish_firing(input logic [15:0] c, input bit have_cmd, input logic [1:0] eerr,
                                 input int ecnt, input string tag);
        int k;
        logic [15:0] ew;
        k = 0;
        while (fc_cnt == base_fc && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " fc_seen"}, 64'(fc_cnt != base_fc), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " fc_once"}, 64'(fc_cnt - base_fc), 64'd1);
        chk({tag, " cmd_err"}, 64'(cmd_err), 64'(eerr));
        if (have_cmd) begin
            prev_instr = c[7:0];
            prev_arg1  = c[9:8];
            prev_arg2  = c[15:11];
        end
        chk({tag, " instr"}, 64'(instr), 64'(prev_instr));
        chk({tag, " arg1"}, 64'(arg1), 64'(prev_arg1));
        chk({tag, " arg2"}, 64'(arg2), 64'(prev_arg2));
        chk({tag, " rd_cmd_cnt"}, 64'(rdc_cnt - base_rdc), 64'(have_cmd ? 1 : 0));
        chk({tag, " rd_data_cnt"}, 64'(rdd_cnt - base_rdd), 64'(ecnt));
        chk({tag, " hs_cnt"}, 64'(hs_word.size() - base_hs), 64'(ecnt));
        for (int i = 0; i < ecnt; i++) begin
            ew = exp_data.pop_front();
            if (base_hs + i < hs_word.size()) begin
                chk($sformatf("%s word%0d", tag, i), 64'(hs_word[base_hs+i]), 64'(ew));
                chk($sformatf("%s idx%0d", tag, i), 64'(hs_idx[base_hs+i]), 64'(i));
            end
        end
        if (!have_cmd) chk({tag, " fc_cycle"}, 64'(fc_cyc), 64'(t0 + 2));
        else if (ecnt == 0) chk({tag, " fc_cycle"}, 64'(fc_cyc), 64'(t0 + 4));
        else chk({tag, " fc_after_hs"}, 64'(fc_cyc), 64'(last_hs_cyc + 1));
        chk({tag, " overlap"}, 64'(overlap - base_ov), 64'd0);
        chk({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [15:0] cmd;
        int          rp;
        logic [1:0]  err;
        int          cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int k, popped, n;
        logic [1:0] e;
        logic [15:0] c;
        logic [7:0] op;
        logic [4:0] a2;

        tbl[0]  = '{16'h0007, 100, 2'd1, 0};
        tbl[1]  = '{16'h6000, 100, 2'd2, 0};
        tbl[2]  = '{16'h0003, 100, 2'd0, 0};
        tbl[3]  = '{16'h0004, 100, 2'd1, 0};
        tbl[4]  = '{16'hF8FF, 100, 2'd1, 0};
        tbl[5]  = '{16'h0302, 100, 2'd2, 0};
        tbl[6]  = '{16'h8802, 100, 2'd2, 0};
        tbl[7]  = '{16'h8002,  60, 2'd0, 16};
        tbl[8]  = '{16'h5000, 100, 2'd0, 11};
        tbl[9]  = '{16'hF800, 100, 2'd2, 0};
        tbl[10] = '{16'hFB01,  50, 2'd0, 1};
        tbl[11] = '{16'h0A00,  40, 2'd0, 2};

        rst = 1'b0;
        invoke = 1'b0;
        prev_instr = '0;
        prev_arg1 = '0;
        prev_arg2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset word_valid", 64'(word_valid), 64'd0);
        chk("reset rd_cmd", 64'(rd_cmd), 64'd0);
        chk("reset rd_data", 64'(rd_data), 64'd0);
        chk("reset FC", 64'(FC), 64'd0);
        chk("reset fields", 64'({instr, arg1, arg2, cmd_err}), 64'd0);
        chk("reset word", 64'({word_out, word_idx}), 64'd0);
        rst = 1'b1;
        @(posedge clk);

        push_data(16'h0003);
        push_data(16'h0005);
        push_data(16'h0007);
        start_firing(16'h1100, 1, 0, 100);
        finish_firing(16'h1100, 1, 2'd0, 3, "stp3");

        push_data(16'($urandom));
        push_data(16'($urandom));
        start_firing(16'h2002, 1, 0, 100);
        repeat (20) @(posedge clk);
        #1;
        chk("evb_wait no rd_data", 64'(rdd_cnt - base_rdd), 64'd0);
        chk("evb_wait busy", 64'(busy), 64'd1);
        push_data(16'($urandom));
        push_data(16'($urandom));
        finish_firing(16'h2002, 1, 2'd0, 4, "evb_wait");

        push_data(16'h0009);
        start_firing(16'h0001, 1, 0, 0);
        k = 0;
        while (word_valid !== 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp offer reached", 64'(word_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp valid%0d", i), 64'(word_valid), 64'd1);
            chk($sformatf("bp word%0d", i), 64'(word_out), 64'h0009);
            chk($sformatf("bp rd_data%0d", i), 64'(rdd_cnt - base_rdd), 64'd1);
        end
        ready_pct = 100;
        finish_firing(16'h0001, 1, 2'd0, 1, "bp");

        start_firing(16'h0000, 0, 0, 100);
        finish_firing(16'h0000, 0, 2'd3, 0, "empty");
        start_firing(16'h0003, 1, 0, 100);
        finish_firing(16'h0003, 1, 2'd0, 0, "rst_cmd");

        start_firing(16'h0800, 1, 2, 0);
        k = 0;
        while (word_valid !== 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("arst offer reached", 64'(word_valid), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst word_valid", 64'(word_valid), 64'd0);
        chk("arst FC", 64'(FC), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst instr/arg2", 64'({instr, arg2}), 64'd0);
        popped = rdd_cnt - base_rdd;
        chk("arst popped", 64'(popped), 64'd1);
        for (int i = 0; i < popped; i++) void'(exp_data.pop_front());
        prev_instr = '0;
        prev_arg1 = '0;
        prev_arg2 = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        start_firing(16'h0001, 1, 0, 100);
        finish_firing(16'h0001, 1, 2'd0, 1, "after_arst");

        for (int i = 0; i < 12; i++) begin
            start_firing(tbl[i].cmd, 1, tbl[i].cnt, tbl[i].rp);
            finish_firing(tbl[i].cmd, 1, tbl[i].err, tbl[i].cnt, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            op = ($urandom_range(9) < 8) ? 8'($urandom_range(3)) : 8'($urandom_range(255));
            a2 = 5'($urandom_range(31));
            if ($urandom_range(3) != 0) a2 = 5'($urandom_range(12));
            c = {a2, 1'($urandom_range(1)), 2'($urandom_range(3)), op};
            model(c, e, n);
            start_firing(c, 1, n + int'($urandom_range(1)), int'($urandom_range(30, 100)));
            finish_firing(c, 1, e, n, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
